dmem: RTL and testbench

Multi-cycle block-addressed data memory that backs the L1 data cache. It stores 128-bit cache blocks and serves one read or write at a time. Each access has a fixed, parameterised latency and uses a ready/done request handshake. The cache controller is its only client.

---
 rtl/dmem.sv | 153 +++++++++++++++
 tb/tb_dmem.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem.sv
// dmem: multi-cycle, block-addressed 128-bit data memory behind the L1 data cache.
// One read or write at a time, fixed LATENCY edges from acceptance to a
// one-cycle done pulse, with a ready/done request handshake.
// Optional feature macro: DMEM_INIT_EN -- when defined, block i starts as
// {4{i[31:0]}} at time zero; otherwise contents are undefined until written.
// Reset never touches the array contents.
module dmem #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ren,
  input  logic         wen,
  input  logic [15:0]  block_address,
  input  logic [127:0] din,
  output logic         ready,
  output logic         done,
  output logic [127:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  typedef logic [127:0] mem_t [DEPTH];

`ifdef DMEM_INIT_EN
  // Power-up image: each block carries its own index replicated four times.
  function automatic mem_t init_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = {4{i[31:0]}};
    end
    return img;
  endfunction

  mem_t mem_array = init_image();
`else
  mem_t mem_array;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [127:0]  wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [127:0]  dout_q, dout_d;
  logic          mem_we_s;
  logic          req_s;

  assign req_s = ren | wen;

  // Next-state, request latching and access-completion logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        // ready_q gates acceptance so the first edge after reset only raises ready.
        if (ready_q && req_s) begin
          state_d = S_BUSY;
          cnt_d   = {CW{1'b0}};
          we_d    = wen;
          idx_d   = block_address[AW-1:0];
          wdata_d = din;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (we_q) begin
            mem_we_s = 1'b1;
          end else begin
            dout_d = mem_array[idx_q];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // A request still held high must be dropped before the next access.
        if (req_s) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Control and output registers; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      we_q    <= 1'b0;
      idx_q   <= {AW{1'b0}};
      wdata_q <= 128'd0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  // Array write port; no reset so contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem (DEPTH=1024, LATENCY=20).
// Expected dout values are pushed to a queue when a request is driven and
// popped when the done pulse is observed.
`timescale 1ns/1ps
module tb_dmem;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 20;

  logic         clock;
  logic         reset;
  logic         ren;
  logic         wen;
  logic [15:0]  block_address;
  logic [127:0] din;
  logic         ready;
  logic         done;
  logic [127:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] model [DEPTH];
  logic [127:0] last_dout;
  logic [127:0] exp_q [$];

  dmem #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock        (clock),
    .reset        (reset),
    .ren          (ren),
    .wen          (wen),
    .block_address(block_address),
    .din          (din),
    .ready        (ready),
    .done         (done),
    .dout         (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record the expected dout of an access as it is issued and update the model.
  task automatic push_expect(input bit is_wr, input logic [15:0] addr, input logic [127:0] data);
    if (is_wr) begin
      exp_q.push_back(last_dout);
      model[addr[9:0]] = data;
    end else begin
      exp_q.push_back(model[addr[9:0]]);
      last_dout = model[addr[9:0]];
    end
  endtask

  // Wait at negedges for ready, bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ready_wait"}, 128'(ready), 128'd1);
  endtask

  // Called #1 after the accepting edge E0: drop the request, scramble the
  // inputs, then check latency, dout and the done fall.
  task automatic finish_access(input string tag);
    int n;
    logic [127:0] exp;
    check({tag, "_busy_ready"}, 128'(ready), 128'd0);
    ren = 1'b0;
    wen = 1'b0;
    block_address = 16'($urandom);
    din = {4{32'($urandom)}};
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clock);
      n++;
      #1;
    end
    check({tag, "_latency"}, 128'(n), 128'(LATENCY));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 128'd0, 128'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_dout"}, dout, exp);
    end
    @(posedge clock);
    #1;
    check({tag, "_done_fall"}, 128'(done), 128'd0);
  endtask

  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [127:0] data);
    @(negedge clock);
    wait_ready(tag);
    ren = rd;
    wen = wr;
    block_address = addr;
    din = data;
    push_expect(wr, addr, data);
    @(posedge clock);
    #1;
    finish_access(tag);
  endtask

  initial begin
    int done_cnt;
    bit saw_ready;
    ren = 1'b0;
    wen = 1'b0;
    block_address = 16'd0;
    din = 128'd0;
    last_dout = 128'd0;
    reset = 1'b0;

    // Reset state.
    #1;
    check("rst_ready", 128'(ready), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_dout", dout, 128'd0);

    // Request already high when reset releases: accepted on the second edge.
    @(negedge clock);
    @(negedge clock);
    wen = 1'b1;
    block_address = 16'd0;
    din = 128'd1;
    push_expect(1'b1, 16'd0, 128'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_edge1_ready", 128'(ready), 128'd1);
    @(posedge clock);
    #1;
    finish_access("post_rst_wr0");

    // Write k+1 to index k then read it back.
    for (int k = 0; k < 32; k++) begin
      access($sformatf("wr%0d", k), 1'b0, 1'b1, 16'(k), 128'(k + 1));
      access($sformatf("rd%0d", k), 1'b1, 1'b0, 16'(k), 128'd0);
    end

    // Held read with a wandering address: one access, latched index only.
    @(negedge clock);
    wait_ready("hold");
    ren = 1'b1;
    block_address = 16'd7;
    push_expect(1'b0, 16'd7, 128'd0);
    done_cnt = 0;
    saw_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clock);
      #1;
      if (ready === 1'b1) saw_ready = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() != 0) check("hold_dout", dout, exp_q.pop_front());
      end
      #1 block_address = 16'((2 * c) % 32);
      #5 block_address = 16'((2 * c + 1) % 32);
    end
    check("hold_done_count", 128'(done_cnt), 128'd1);
    check("hold_ready_stayed_low", 128'(saw_ready), 128'd0);
    @(negedge clock);
    ren = 1'b0;
    @(posedge clock);
    #1;
    check("hold_release_ready", 128'(ready), 128'd1);

    // Simultaneous ren/wen: write wins, dout untouched by the write.
    access("both_wr5", 1'b1, 1'b1, 16'd5, 128'hAA);
    access("both_rd5", 1'b1, 1'b0, 16'd5, 128'd0);

    // Upper address bits ignored.
    access("hi_wr", 1'b0, 1'b1, 16'hFC05, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
    access("hi_rd", 1'b1, 1'b0, 16'h0405, 128'd0);

    // Reset in the middle of a write to index 4: aborted, no array update.
    @(negedge clock);
    wait_ready("abort");
    wen = 1'b1;
    block_address = 16'd4;
    din = 128'hDEAD_BEEF;
    @(posedge clock);
    #1;
    wen = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_ready", 128'(ready), 128'd0);
    check("abort_done", 128'(done), 128'd0);
    check("abort_dout", dout, 128'd0);
    last_dout = 128'd0;
    @(negedge clock);
    reset = 1'b1;
    done_cnt = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 128'(done_cnt), 128'd0);
    access("abort_rd4", 1'b1, 1'b0, 16'd4, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
